// File: rtl/noc_traffic_gen_pkg.sv
// Shared types and helpers for the NoC traffic generator.
//   flit_type_t : 2-bit flit type carried in the top bits of every flit
//   tg_state_e  : generator FSM state, encoded with ST_* localparams
//   tg_cfg_t    : per-packet configuration snapshot
//   lfsr32_next : one step of the 32-bit Galois LFSR x^32+x^22+x^2+x+1
package noc_traffic_gen_pkg;

    localparam int unsigned TYPE_W = 2;

    typedef enum logic [TYPE_W-1:0] {
        TYPE_NONE = 2'd0,
        TYPE_HEAD = 2'd1,
        TYPE_DATA = 2'd2,
        TYPE_TAIL = 2'd3
    } flit_type_t;

    typedef logic [2:0] tg_state_e;

    localparam tg_state_e ST_IDLE = 3'd0;
    localparam tg_state_e ST_HEAD = 3'd1;
    localparam tg_state_e ST_BODY = 3'd2;
    localparam tg_state_e ST_TAIL = 3'd3;
    localparam tg_state_e ST_GAP  = 3'd4;

    typedef struct packed {
        logic [15:0] pkt_num;
        logic [7:0]  gap;
        logic [7:0]  len;
    } tg_cfg_t;

    // Right-shifting Galois form: taps 32,22,2,1 map to mask bits 31,21,1,0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr32_next(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/noc_traffic_gen_if.sv
// Flit link between a traffic generator and a router input port.
//   data  : {flit type, payload}, driven by master
//   vch   : virtual channel of the current packet, driven by master
//   valid : flit valid, driven by master
//   ack   : per-VC ready, driven by slave; a flit moves when valid && ack[vch]
interface noc_traffic_gen_if #(
    parameter int unsigned VCH_N  = 4,
    parameter int unsigned VCH_W  = (VCH_N > 1) ? $clog2(VCH_N) : 1,
    parameter int unsigned DATA_W = 32
);
    import noc_traffic_gen_pkg::*;

    logic [TYPE_W+DATA_W-1:0] data;
    logic [VCH_W-1:0]         vch;
    logic                     valid;
    logic [VCH_N-1:0]         ack;

    modport master (output data, output vch, output valid, input ack);
    modport slave  (input data, input vch, input valid, output ack);

endinterface

// File: rtl/noc_traffic_gen_lfsr32.sv
// 32-bit Galois LFSR payload source.
//   clk, rst_n : clock, asynchronous active-low reset (loads SEED, 0 replaced by 1)
//   advance    : step the register once this cycle
//   value      : current LFSR state, never zero
module noc_traffic_gen_lfsr32
    import noc_traffic_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [31:0] value
);

    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED_NZ;
        end else if (advance) begin
            value <= lfsr32_next(value);
        end
    end

endmodule

// File: rtl/noc_traffic_gen.sv
// Wormhole packet source for one router input port.
// Emits HEAD, cfg_len DATA flits and a TAIL, then cfg_gap idle cycles; packets rotate over VCs.
//   clk, rst_n         : clock, asynchronous active-low reset
//   en                 : generate packets while high; low also clears done
//   cfg_len/gap/pkt_num: DATA flits per packet, idle cycles after TAIL, packet limit (0 = none)
//   cfg_rand_dst       : 1 = LFSR-chosen destination, 0 = cfg_dst_x/y
//   my_xpos/ypos       : own node, never used as a random destination
//   link (master)      : data/vch/valid out, per-VC ack in
//   busy               : packet in flight, HEAD through TAIL acceptance
//   done               : cfg_pkt_num packets sent
// Optional macro NOC_TG_STATS_EN adds saturating flit_cnt, pkt_cnt and stall_cnt outputs.
module noc_traffic_gen
    import noc_traffic_gen_pkg::*;
#(
    parameter int unsigned VCH_N     = 4,
    parameter int unsigned VCH_W     = (VCH_N > 1) ? $clog2(VCH_N) : 1,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] LFSR_SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  cfg_len,
    input  logic [7:0]  cfg_gap,
    input  logic [15:0] cfg_pkt_num,
    input  logic        cfg_rand_dst,
    input  logic [1:0]  cfg_dst_x,
    input  logic [1:0]  cfg_dst_y,
    input  logic [1:0]  my_xpos,
    input  logic [1:0]  my_ypos,
    noc_traffic_gen_if.master link,
    output logic        busy,
    output logic        done
`ifdef NOC_TG_STATS_EN
    ,
    output logic [31:0] flit_cnt,
    output logic [31:0] pkt_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned FLIT_W = TYPE_W + DATA_W;

    tg_state_e           state_q, state_d;
    tg_cfg_t             cfg_q, cfg_d;
    logic [7:0]          beat_q, beat_d;
    logic [7:0]          gap_q, gap_d;
    logic [15:0]         pkts_q, pkts_d;
    logic [VCH_W-1:0]    vc_ptr_q, vc_ptr_d;
    logic [VCH_W-1:0]    vch_q, vch_d;
    logic [FLIT_W-1:0]   data_q, data_d;
    logic                done_q, done_d;

    logic [31:0]         lfsr, lfsr_next, lfsr_now;
    logic                lfsr_adv;
    logic                valid, accept, start, last_beat;
    logic [1:0]          dst_x, dst_y;

    noc_traffic_gen_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (lfsr_adv),
        .value   (lfsr)
    );

    assign lfsr_next = lfsr32_next(lfsr);

    assign valid  = (state_q == ST_HEAD) || (state_q == ST_BODY) || (state_q == ST_TAIL);
    assign accept = valid && link.ack[vch_q];

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        pkts_d    = pkts_q;
        vc_ptr_d  = vc_ptr_q;
        vch_d     = vch_q;
        data_d    = data_q;
        done_d    = done_q;
        lfsr_adv  = 1'b0;
        start     = 1'b0;
        last_beat = 1'b0;
        lfsr_now  = lfsr;
        dst_x     = cfg_dst_x;
        dst_y     = cfg_dst_y;

        case (state_q)
            ST_IDLE: begin
                if (en && !done_q) begin
                    start  = 1'b1;
                    pkts_d = '0;
                end
            end
            ST_HEAD: begin
                if (accept) begin
                    beat_d = '0;
                    if (cfg_q.len == 8'd0) begin
                        state_d = ST_TAIL;
                        data_d  = {TYPE_TAIL, DATA_W'(lfsr)};
                    end else begin
                        state_d = ST_BODY;
                        data_d  = {TYPE_DATA, DATA_W'(lfsr)};
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    lfsr_adv  = 1'b1;
                    beat_d    = beat_q + 8'd1;
                    last_beat = (beat_d == cfg_q.len);
                    state_d   = last_beat ? ST_TAIL : ST_BODY;
                    data_d    = {last_beat ? TYPE_TAIL : TYPE_DATA, DATA_W'(lfsr_next)};
                end
            end
            ST_TAIL: begin
                if (accept) begin
                    lfsr_adv = 1'b1;
                    vc_ptr_d = (vc_ptr_q == VCH_W'(VCH_N - 1)) ? '0 : vc_ptr_q + 1'b1;
                    pkts_d   = pkts_q + 16'd1;
                    data_d   = {TYPE_NONE, DATA_W'(0)};
                    gap_d    = '0;
                    state_d  = ST_GAP;
                    if (cfg_q.pkt_num != 16'd0 && pkts_d == cfg_q.pkt_num) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cfg_q.gap == 8'd0) begin
                        // No gap: next HEAD follows the TAIL back-to-back.
                        if (en) begin
                            start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == cfg_q.gap - 8'd1) begin
                    if (en) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = {TYPE_NONE, DATA_W'(0)};
            end
        endcase

        if (start) begin
            // Random destination uses the LFSR value the packet's first payload flit will carry.
            lfsr_now = lfsr_adv ? lfsr_next : lfsr;
            if (cfg_rand_dst) begin
                dst_x = lfsr_now[1:0];
                dst_y = lfsr_now[3:2];
                if (dst_x == my_xpos && dst_y == my_ypos) begin
                    dst_x = dst_x + 2'd1;
                end
            end
            cfg_d.len     = cfg_len;
            cfg_d.gap     = cfg_gap;
            cfg_d.pkt_num = cfg_pkt_num;
            state_d       = ST_HEAD;
            vch_d         = vc_ptr_d;
            data_d        = {TYPE_HEAD, DATA_W'({dst_y, dst_x})};
        end

        if (!en) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cfg_q    <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            pkts_q   <= '0;
            vc_ptr_q <= '0;
            vch_q    <= '0;
            data_q   <= {TYPE_NONE, DATA_W'(0)};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            pkts_q   <= pkts_d;
            vc_ptr_q <= vc_ptr_d;
            vch_q    <= vch_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign link.data  = data_q;
    assign link.vch   = vch_q;
    assign link.valid = valid;
    assign busy       = valid;
    assign done       = done_q;

`ifdef NOC_TG_STATS_EN
    logic [31:0] flit_cnt_q, pkt_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && flit_cnt_q != '1) begin
                flit_cnt_q <= flit_cnt_q + 32'd1;
            end
            if (accept && state_q == ST_TAIL && pkt_cnt_q != '1) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (valid && !link.ack[vch_q] && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign flit_cnt  = flit_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
